// File: rtl/cfg_timer_pkg.sv
// Package: cfg_timer_pkg
// Shared types and constants for the configurable interval timer:
//   - FSM state encoding
//   - CTRL register bit positions and config byte indices
//   - spare_sel encodings
//   - rising-edge helper used by the event detectors
`timescale 1ns/1ps
package cfg_timer_pkg;

    localparam int PRESC_WIDTH = 8;
    localparam int SPARE_WIDTH = 8;
    localparam int STATUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

    // CTRL (cfg0) bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_IRQ_CLR  = 3;
    localparam int CTRL_SW_START = 4;
    localparam int CTRL_SW_STOP  = 5;
    localparam int CTRL_SPSEL    = 6;   // two bits: [7:6]

    // Config byte indices
    localparam int CFG_CTRL   = 0;
    localparam int CFG_PRESC  = 1;
    localparam int CFG_CMP_LO = 2;
    localparam int CFG_CMP_HI = 3;

    // spare_sel encodings
    localparam logic [1:0] SPSEL_CNT_LO = 2'd0;
    localparam logic [1:0] SPSEL_CNT_HI = 2'd1;
    localparam logic [1:0] SPSEL_FLAGS  = 2'd2;
    localparam logic [1:0] SPSEL_PRESC  = 2'd3;

    // Rising edge of a level given its one-cycle-delayed copy.
    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/cfg_timer_irq_prescaler.sv
// Module: timer_prescaler
// Divides the clock for the timer counter. While running, the counter walks
// 0..i_prescale and o_tick is high on the cycle it equals i_prescale, after
// which it wraps to 0. The counter is held at 0 whenever the timer will not
// be running in the next cycle (covers stop, disable and fresh entry to RUN).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_ena        global enable; counter only advances when high
//   i_run        timer currently in RUN
//   i_clear      force the counter to 0 at the next edge
//   i_prescale   terminal count
//   o_tick       prescaled tick (combinational from the counter)
//   o_presc_cnt  current prescaler count
`timescale 1ns/1ps
module timer_prescaler
    import cfg_timer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_ena,
    input  logic                   i_run,
    input  logic                   i_clear,
    input  logic [PRESC_WIDTH-1:0] i_prescale,
    output logic                   o_tick,
    output logic [PRESC_WIDTH-1:0] o_presc_cnt
);

    localparam logic [PRESC_WIDTH-1:0] LP_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESC_WIDTH-1:0] r_cnt;
    logic [PRESC_WIDTH-1:0] w_cnt_next;
    logic                   w_tick;

    assign w_tick = i_run & (r_cnt == i_prescale);

    // Next count: clear, wrap on tick, otherwise increment (8-bit wrap lets a
    // lowered prescale value be reached again eventually).
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear || !i_run || w_tick) begin
            w_cnt_next = {PRESC_WIDTH{1'b0}};
        end else begin
            w_cnt_next = r_cnt + LP_ONE;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {PRESC_WIDTH{1'b0}};
        end else if (i_ena) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_tick      = w_tick;
    assign o_presc_cnt = r_cnt;

endmodule

// File: rtl/synchronizer.sv
// Module: synchronizer
// Multi-stage flop synchronizer for asynchronous inputs. Stages only shift
// while i_en is high so a frozen design also freezes its input history.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_en        shift enable
//   i_d         asynchronous input
//   o_q         synchronized output (last stage)
`timescale 1ns/1ps
module synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    // Shift chain: stage 0 samples the pin, later stages follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= {WIDTH{1'b0}};
            end
        end else if (i_en) begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cfg_timer_irq.sv
// Module: cfg_timer_irq
// Programmable interval timer driven by the SPI config register bank.
// Start/stop come from synchronized GPIO pins or from software CTRL bits.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          global enable; every register advances only when high
//   gpio_start   asynchronous start pin
//   gpio_stop    asynchronous stop pin
//   config_regs  config bytes, byte n at [8n+7:8n]
//   irq          registered level interrupt
//   spare        registered debug byte selected by CTRL[7:6]
//   status_out   registered {count[15:0], 8'h00, 4'h0, overrun, pending, state}
`timescale 1ns/1ps
module cfg_timer_irq
    import cfg_timer_pkg::*;
#(
    parameter int NUM_CFG     = 8,
    parameter int REG_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         gpio_start,
    input  logic                         gpio_stop,
    input  logic [NUM_CFG*REG_WIDTH-1:0] config_regs,
    output logic                         irq,
    output logic [SPARE_WIDTH-1:0]       spare,
    output logic [STATUS_WIDTH-1:0]      status_out
);

    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Config decode
    logic [REG_WIDTH-1:0]   w_ctrl;
    logic [PRESC_WIDTH-1:0] w_presc;
    logic [CNT_WIDTH-1:0]   w_cmp;
    logic                   w_unused_cfg;

    assign w_ctrl  = config_regs[CFG_CTRL*REG_WIDTH +: REG_WIDTH];
    assign w_presc = config_regs[CFG_PRESC*REG_WIDTH +: PRESC_WIDTH];
    assign w_cmp   = {config_regs[CFG_CMP_HI*REG_WIDTH +: REG_WIDTH],
                      config_regs[CFG_CMP_LO*REG_WIDTH +: REG_WIDTH]};
    // Bytes 4 and up carry nothing for this block.
    assign w_unused_cfg = ^config_regs[NUM_CFG*REG_WIDTH-1:4*REG_WIDTH];

    // Synchronized pins
    logic w_gs_sync;
    logic w_gp_sync;

    synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (ena),
        .i_d   (gpio_start),
        .o_q   (w_gs_sync)
    );

    synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (ena),
        .i_d   (gpio_stop),
        .o_q   (w_gp_sync)
    );

    // Edge-detect history
    logic r_gs_q, r_gp_q, r_sws_q, r_swp_q, r_clr_q;
    logic w_start, w_stop, w_clr;

    // One-cycle delayed copies of every event source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gs_q  <= 1'b0;
            r_gp_q  <= 1'b0;
            r_sws_q <= 1'b0;
            r_swp_q <= 1'b0;
            r_clr_q <= 1'b0;
        end else if (ena) begin
            r_gs_q  <= w_gs_sync;
            r_gp_q  <= w_gp_sync;
            r_sws_q <= w_ctrl[CTRL_SW_START];
            r_swp_q <= w_ctrl[CTRL_SW_STOP];
            r_clr_q <= w_ctrl[CTRL_IRQ_CLR];
        end
    end

    assign w_start = rise(w_gs_sync, r_gs_q) | rise(w_ctrl[CTRL_SW_START], r_sws_q);
    assign w_stop  = rise(w_gp_sync, r_gp_q) | rise(w_ctrl[CTRL_SW_STOP], r_swp_q);
    assign w_clr   = rise(w_ctrl[CTRL_IRQ_CLR], r_clr_q);

    // Core state
    timer_state_e           r_state, w_state_next;
    logic [CNT_WIDTH-1:0]   r_count, w_count_next;
    logic                   r_pend, w_pend_next;
    logic                   r_ovr, w_ovr_next;
    logic                   w_match;
    logic                   w_tick;
    logic [PRESC_WIDTH-1:0] w_presc_cnt;

    // Prescaler is held at 0 unless the timer stays in RUN through this edge.
    timer_prescaler u_presc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ena       (ena),
        .i_run       (r_state == ST_RUN),
        .i_clear     (w_state_next != ST_RUN),
        .i_prescale  (w_presc),
        .o_tick      (w_tick),
        .o_presc_cnt (w_presc_cnt)
    );

    // State register together with the counter and interrupt flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= {CNT_WIDTH{1'b0}};
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_pend  <= w_pend_next;
            r_ovr   <= w_ovr_next;
        end
    end

    // Next state and count. Disable overrides everything; stop beats start.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_match      = 1'b0;
        if (!w_ctrl[CTRL_EN]) begin
            w_state_next = ST_IDLE;
            w_count_next = {CNT_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_stop) begin
                        w_state_next = ST_RUN;
                        w_count_next = {CNT_WIDTH{1'b0}};
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_stop) begin
                        w_state_next = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_count == w_cmp) begin
                            w_match = 1'b1;
                            if (w_ctrl[CTRL_AUTO]) begin
                                w_count_next = {CNT_WIDTH{1'b0}};
                            end else begin
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_count_next = r_count + LP_CNT_ONE;
                        end
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_stop) begin
                        w_state_next = ST_IDLE;
                    end else if (w_start) begin
                        w_state_next = ST_RUN;
                        w_count_next = {CNT_WIDTH{1'b0}};
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = {CNT_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Output-side next values: interrupt flags, irq, spare and status.
    logic                    w_irq_next;
    logic [SPARE_WIDTH-1:0]  w_spare_next;
    logic [STATUS_WIDTH-1:0] w_status_next;

    always_comb begin
        w_pend_next  = r_pend;
        w_ovr_next   = r_ovr;
        w_spare_next = {SPARE_WIDTH{1'b0}};
        if (!w_ctrl[CTRL_EN]) begin
            w_pend_next = 1'b0;
            w_ovr_next  = 1'b0;
        end else if (w_match) begin
            // Set wins over clear for pending; a coincident clear still
            // clears overrun and suppresses setting it.
            w_pend_next = 1'b1;
            w_ovr_next  = w_clr ? 1'b0 : (r_ovr | r_pend);
        end else if (w_clr) begin
            w_pend_next = 1'b0;
            w_ovr_next  = 1'b0;
        end else begin
            w_pend_next = r_pend;
            w_ovr_next  = r_ovr;
        end

        case (w_ctrl[CTRL_SPSEL +: 2])
            SPSEL_CNT_LO: w_spare_next = r_count[7:0];
            SPSEL_CNT_HI: w_spare_next = r_count[15:8];
            SPSEL_FLAGS:  w_spare_next = {4'h0, r_ovr, r_pend, r_state};
            SPSEL_PRESC:  w_spare_next = w_presc_cnt;
            default:      w_spare_next = {SPARE_WIDTH{1'b0}};
        endcase
    end

    assign w_irq_next    = w_pend_next & w_ctrl[CTRL_IRQ_EN];
    // Status mirrors the state registers as they will be after this edge.
    assign w_status_next = {w_count_next[15:0], 8'h00, 4'h0,
                            w_ovr_next, w_pend_next, w_state_next};

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq        <= 1'b0;
            spare      <= {SPARE_WIDTH{1'b0}};
            status_out <= {STATUS_WIDTH{1'b0}};
        end else if (ena) begin
            irq        <= w_irq_next;
            spare      <= w_spare_next;
            status_out <= w_status_next;
        end
    end

endmodule

// File: tb/tb_cfg_timer_irq.sv
`timescale 1ns/1ps
module tb_cfg_timer_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        gpio_start;
    logic        gpio_stop;
    logic [63:0] config_regs;
    logic        irq;
    logic [7:0]  spare;
    logic [31:0] status_out;

    always #5 clk = ~clk;

    cfg_timer_irq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .gpio_start  (gpio_start),
        .gpio_stop   (gpio_stop),
        .config_regs (config_regs),
        .irq         (irq),
        .spare       (spare),
        .status_out  (status_out)
    );

    wire [40:0] w_dut = {irq, spare, status_out};

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural reference model (state kept as plain integers)
    int       m_state, m_count, m_presc, m_spare;
    bit       m_pend, m_ovr, m_irq;
    bit [1:0] m_sy_start, m_sy_stop;
    bit       m_prev_gs, m_prev_gp, m_prev_sws, m_prev_swp, m_prev_clr;

    function automatic logic [40:0] model_vec();
        logic [31:0] st;
        st = (32'(m_count) << 16) | (32'(m_ovr) << 3) | (32'(m_pend) << 2) | 32'(m_state);
        return {m_irq, 8'(m_spare), st};
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_presc = 0; m_spare = 0;
        m_pend = 0; m_ovr = 0; m_irq = 0;
        m_sy_start = 2'b00; m_sy_stop = 2'b00;
        m_prev_gs = 0; m_prev_gp = 0; m_prev_sws = 0; m_prev_swp = 0; m_prev_clr = 0;
    endtask

    task automatic model_update(input bit p_ena, input bit p_gs, input bit p_gp,
                                input logic [63:0] p_cfg);
        int  ctrl, presc, cmp, n_state, n_count, n_presc;
        bit  en, start_ev, stop_ev, clr_ev, tk, match;
        if (!p_ena) return;
        ctrl  = int'(p_cfg[7:0]);
        presc = int'(p_cfg[15:8]);
        cmp   = int'(p_cfg[31:16]);
        en    = ctrl[0];
        start_ev = (m_sy_start[1] && !m_prev_gs) || (ctrl[4] && !m_prev_sws);
        stop_ev  = (m_sy_stop[1]  && !m_prev_gp) || (ctrl[5] && !m_prev_swp);
        clr_ev   = ctrl[3] && !m_prev_clr;
        case ((ctrl >> 6) & 3)
            0:       m_spare = m_count % 256;
            1:       m_spare = m_count / 256;
            2:       m_spare = m_ovr * 8 + m_pend * 4 + m_state;
            default: m_spare = m_presc;
        endcase
        tk = (m_state == 1) && (m_presc == presc);
        match = 0; n_state = m_state; n_count = m_count;
        if (!en) begin
            n_state = 0; n_count = 0;
        end else if (m_state == 0) begin
            if (start_ev && !stop_ev) begin n_state = 1; n_count = 0; end
        end else if (m_state == 1) begin
            if (stop_ev) n_state = 0;
            else if (tk) begin
                if (m_count == cmp) begin
                    match = 1;
                    if (ctrl[1]) n_count = 0; else n_state = 2;
                end else n_count = (m_count + 1) % 65536;
            end
        end else begin
            if (stop_ev) n_state = 0;
            else if (start_ev) begin n_state = 1; n_count = 0; end
        end
        n_presc = (m_state == 1 && n_state == 1 && !tk) ? (m_presc + 1) % 256 : 0;
        if (!en)                  begin m_pend = 0; m_ovr = 0; end
        else begin
            if (clr_ev)               m_ovr = 0;
            else if (match && m_pend) m_ovr = 1;
            if (match)                m_pend = 1;
            else if (clr_ev)          m_pend = 0;
        end
        m_irq = m_pend && ctrl[2];
        m_state = n_state; m_count = n_count; m_presc = n_presc;
        m_prev_gs = m_sy_start[1]; m_prev_gp = m_sy_stop[1];
        m_sy_start = {m_sy_start[0], p_gs}; m_sy_stop = {m_sy_stop[0], p_gp};
        m_prev_sws = ctrl[4]; m_prev_swp = ctrl[5]; m_prev_clr = ctrl[3];
    endtask

    // Advance one clock: sample inputs before the edge, look at outputs 1 ns after it.
    task automatic tick();
        bit          p_ena = ena;
        bit          p_gs  = gpio_start;
        bit          p_gp  = gpio_stop;
        logic [63:0] p_cfg = config_regs;
        @(posedge clk);
        #1;
        model_update(p_ena, p_gs, p_gp, p_cfg);
    endtask

    task automatic set_cfg(input logic [7:0] ctrl, input logic [7:0] presc, input logic [15:0] cmp);
        config_regs = {32'h0, cmp, presc, ctrl};
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; gpio_start = 1'b0; gpio_stop = 1'b0;
        config_regs = 64'h0;
        #12;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (w_dut !== 41'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0", w_dut);
        end
        repeat (4) begin
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL reset_idle: got %h expected %h", w_dut, model_vec());
            end
        end
    endtask

    task automatic test_auto_reload();
        int first_irq = -1;
        do_reset();
        set_cfg(8'h07, 8'd0, 16'd4);
        tick();
        set_cfg(8'h17, 8'd0, 16'd4);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (irq === 1'b1 && first_irq < 0) first_irq = k;
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL auto_reload cyc%0d: got %h expected %h", k, w_dut, model_vec());
            end
        end
        n_cmp++;
        if (first_irq != 6) begin
            n_err++;
            $display("FAIL auto_reload_first_irq: got cycle %0d expected 6", first_irq);
        end
        n_cmp++;
        if (status_out[2] !== 1'b1 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL auto_reload_pending: got pend=%b irq=%b expected 1/1", status_out[2], irq);
        end
    endtask

    task automatic test_one_shot_gpio();
        do_reset();
        set_cfg(8'h01, 8'd3, 16'd2);
        gpio_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            gpio_start = 1'b0;
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL one_shot cyc%0d: got %h expected %h", k, w_dut, model_vec());
            end
            if (k == 2 || k == 3 || k == 14 || k == 15) begin
                n_cmp++;
                if (status_out[1:0] !== ((k == 2) ? 2'd0 : (k == 15) ? 2'd2 : 2'd1)) begin
                    n_err++;
                    $display("FAIL one_shot_state cyc%0d: got %0d", k, status_out[1:0]);
                end
            end
        end
        n_cmp++;
        if (status_out[31:16] !== 16'd2 || status_out[1:0] !== 2'd2) begin
            n_err++;
            $display("FAIL one_shot_done: got count=%0d state=%0d expected 2/2",
                     status_out[31:16], status_out[1:0]);
        end
    endtask

    task automatic test_overrun_clear();
        int k = 0;
        do_reset();
        set_cfg(8'h07, 8'd0, 16'd7);
        tick();
        set_cfg(8'h17, 8'd0, 16'd7);
        while (!m_ovr && k < 40) begin
            tick(); k++;
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL overrun cyc%0d: got %h expected %h", k, w_dut, model_vec());
            end
        end
        n_cmp++;
        if (k != 17 || status_out[3:2] !== 2'b11) begin
            n_err++;
            $display("FAIL overrun_set: got cycle %0d flags=%b expected 17/11", k, status_out[3:2]);
        end
        set_cfg(8'h1F, 8'd0, 16'd7);
        tick();
        n_cmp++;
        if (status_out[3:2] !== 2'b00 || irq !== 1'b0 || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL overrun_clear: got flags=%b irq=%b expected 00/0", status_out[3:2], irq);
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        set_cfg(8'h01, 8'd0, 16'd200);
        tick();
        gpio_start = 1'b1; gpio_stop = 1'b1;
        repeat (6) begin
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL collide: got %h expected %h", w_dut, model_vec());
            end
        end
        n_cmp++;
        if (status_out[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL collide_idle: got state %0d expected 0", status_out[1:0]);
        end
        gpio_start = 1'b0; gpio_stop = 1'b0;
        repeat (3) tick();
        set_cfg(8'h11, 8'd0, 16'd200);
        repeat (10) begin
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL sw_run: got %h expected %h", w_dut, model_vec());
            end
        end
        set_cfg(8'h31, 8'd0, 16'd200);
        repeat (3) begin
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL sw_stop: got %h expected %h", w_dut, model_vec());
            end
        end
        n_cmp++;
        if (status_out[31:16] !== 16'd9 || status_out[1:0] !== 2'd0 || spare !== 8'd9) begin
            n_err++;
            $display("FAIL sw_stop_frozen: got count=%0d state=%0d spare=%0d expected 9/0/9",
                     status_out[31:16], status_out[1:0], spare);
        end
    endtask

    task automatic test_match_clear_disable();
        do_reset();
        set_cfg(8'h07, 8'd0, 16'd3);
        tick();
        set_cfg(8'h17, 8'd0, 16'd3);
        repeat (4) tick();
        set_cfg(8'h1F, 8'd0, 16'd3);
        tick();
        n_cmp++;
        if (status_out[3:2] !== 2'b01 || irq !== 1'b1 || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL match_clr: got flags=%b irq=%b expected 01/1", status_out[3:2], irq);
        end
        set_cfg(8'h17, 8'd0, 16'd3);
        repeat (6) begin
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL match_clr_run: got %h expected %h", w_dut, model_vec());
            end
        end
        set_cfg(8'h16, 8'd0, 16'd3);
        tick();
        n_cmp++;
        if (status_out !== 32'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL disable: got status=%h irq=%b expected 0/0", status_out, irq);
        end
    endtask

    task automatic test_async_reset_full_count();
        int k = 0;
        do_reset();
        set_cfg(8'h07, 8'd0, 16'd50);
        tick();
        set_cfg(8'h17, 8'd0, 16'd50);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_dut !== 41'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 0", w_dut);
        end
        model_reset();
        set_cfg(8'h01, 8'd0, 16'hFFFF);
        #3;
        rst_n = 1'b1;
        tick();
        set_cfg(8'h11, 8'd0, 16'hFFFF);
        while (m_state != 2 && k < 70000) begin
            tick(); k++;
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL full_count cyc%0d: got %h expected %h", k, w_dut, model_vec());
            end
        end
        n_cmp++;
        if (k != 65537 || status_out[31:16] !== 16'hFFFF || status_out[1:0] !== 2'd2) begin
            n_err++;
            $display("FAIL full_count_done: got cycles=%0d count=%h state=%0d expected 65537/ffff/2",
                     k, status_out[31:16], status_out[1:0]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  ctrl;
        logic [7:0]  presc;
        logic [15:0] cmp;
        do_reset();
        ctrl = 8'h01; presc = 8'd1; cmp = 16'd3;
        for (int k = 0; k < 2000; k++) begin
            ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) gpio_start = ~gpio_start;
            if ($urandom_range(0, 11) == 0) gpio_stop = ~gpio_stop;
            if ($urandom_range(0, 9) == 0) begin
                ctrl = 8'($urandom);
                ctrl[0] = ($urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 49) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) cmp = 16'($urandom_range(0, 6));
            config_regs = {32'($urandom), cmp, presc, ctrl};
            tick();
            n_cmp++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h expected %h", k, w_dut, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_one_shot_gpio();
        test_overrun_clear();
        test_start_stop();
        test_match_clear_disable();
        test_random();
        test_async_reset_full_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
